// File: rtl/hack_rom_loader_if.sv
// Byte-stream input and ROM write port of the Hack ROM boot loader.
// The slave modport is the loader's view; master is the side that feeds bytes and owns the ROM.
interface hack_rom_loader_if #(
  parameter int ADDR_W = 14
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [0:15]       rom_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  rom_we,
    input  rom_addr,
    input  rom_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output rom_we,
    output rom_addr,
    output rom_wdata
  );
endinterface

// File: rtl/hack_rom_loader.sv
// Boot loader for the Hack instruction ROM: parses N, N words, CSUM (all big-endian) from a
// byte stream, writes the words from address 0 and releases cpu_reset only on a good checksum.
module hack_rom_loader #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic             clk,
  input  logic             reset,
  hack_rom_loader_if.slave bus,
  input  logic             start,
  output logic             cpu_reset,
  output logic             load_done,
  output logic             load_error,
  output logic [15:0]      words_loaded
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA_HI,
    DATA_LO,
    SUM_HI,
    SUM_LO,
    DONE,
    ERROR
  } state_t;

  // One extra bit so that a header equal to 0xFFFF still compares correctly against DEPTH.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       rom_wdata_q, rom_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       words_q, words_d;
  logic [15:0]       sum_q, sum_d;
  logic [7:0]        byte_hi_q, byte_hi_d;
  logic [15:0]       n_q, n_d;

  logic              xfer;
  logic [15:0]       word;
  logic [15:0]       words_inc;

  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] w);
    return acc + w;
  endfunction

  function automatic logic accepts_bytes(input state_t s);
    return (s != DONE) && (s != ERROR);
  endfunction

  assign xfer      = bus.in_valid & in_ready_q;
  assign word      = {byte_hi_q, bus.in_data};
  assign words_inc = words_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    words_d     = words_q;
    sum_d       = sum_q;
    byte_hi_d   = byte_hi_q;
    n_d         = n_q;

    case (state_q)
      HDR_HI: begin
        if (xfer) begin
          byte_hi_d = bus.in_data;
          state_d   = HDR_LO;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          n_d = word;
          if ({1'b0, word} > DEPTH_L) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else if (word == 16'd0) begin
            state_d = SUM_HI;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (xfer) begin
          byte_hi_d = bus.in_data;
          state_d   = DATA_LO;
        end
      end
      DATA_LO: begin
        // The word index before incrementing is the ROM address of this word.
        if (xfer) begin
          rom_we_d    = 1'b1;
          rom_addr_d  = words_q[ADDR_W-1:0];
          rom_wdata_d = word;
          sum_d       = csum_add(sum_q, word);
          words_d     = words_inc;
          state_d     = (words_inc == n_q) ? SUM_HI : DATA_HI;
        end
      end
      SUM_HI: begin
        if (xfer) begin
          byte_hi_d = bus.in_data;
          state_d   = SUM_LO;
        end
      end
      SUM_LO: begin
        if (xfer) begin
          if (word == sum_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
      end
      DONE, ERROR: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          words_d = 16'd0;
          sum_d   = 16'd0;
          state_d = HDR_HI;
        end
      end
      default: state_d = HDR_HI;
    endcase

    // Handshake and CPU reset are registered from the next state so they line up with it.
    in_ready_d  = accepts_bytes(state_d);
    cpu_reset_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR_HI;
      in_ready_q  <= 1'b1;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
      words_q     <= words_d;
      sum_q       <= sum_d;
    end
    byte_hi_q <= byte_hi_d;
    n_q       <= n_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.rom_we    = rom_we_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign load_done     = done_q;
  assign load_error    = err_q;
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Bench for hack_rom_loader: directed frame table, reset/start sequences and random frames
// checked against a frame-level reference model.
module tb_hack_rom_loader;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 16384;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;
  typedef struct packed {
    logic [95:0] bytes;
    logic [3:0]  len;
    logic [2:0]  gap;
    logic        done;
    logic        err;
    logic [15:0] words;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cpu_reset, load_done, load_error;
  logic [15:0] words_loaded;

  int errors = 0;
  int checks = 0;

  wr_t got[$];
  wr_t expq[$];
  bit  m_done, m_err;
  int  m_words;

  hack_rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

  hack_rom_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .start       (start),
    .cpu_reset   (cpu_reset),
    .load_done   (load_done),
    .load_error  (load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    wr_t w;
    #1;
    if (bus.rom_we === 1'b1) begin
      w.addr = 16'(bus.rom_addr);
      w.data = bus.rom_wdata;
      got.push_back(w);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 900000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: interpret a complete frame directly from its byte-level definition.
  task automatic model(input bq_t q);
    int          n;
    logic [15:0] sum, w, cs;
    wr_t         e;
    expq.delete();
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_words = 0;
    n = int'({q[0], q[1]});
    if (n > DEPTH) begin
      m_err = 1'b1;
      return;
    end
    sum = 16'd0;
    for (int i = 0; i < n; i++) begin
      w = {q[2 + 2 * i], q[3 + 2 * i]};
      sum = sum + w;
      e.addr = 16'(i);
      e.data = w;
      expq.push_back(e);
    end
    m_words = n;
    cs = {q[2 + 2 * n], q[3 + 2 * n]};
    m_done = (cs == sum);
    m_err  = !m_done;
  endtask

  task automatic send_frame(input bq_t q, input int max_gap);
    foreach (q[i]) begin
      int gap;
      int t;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      t = 0;
      repeat (gap) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = q[i];
      while (bus.in_ready !== 1'b1 && t < 64) begin
        @(negedge clk);
        t++;
      end
      if (bus.in_ready !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL byte_accept: byte %0d never accepted, in_ready=%b required 1", i, bus.in_ready);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"},     32'(bus.in_ready),   32'd1);
    check({tag, ".cpu_reset"},    32'(cpu_reset),      32'd1);
    check({tag, ".load_done"},    32'(load_done),      32'd0);
    check({tag, ".load_error"},   32'(load_error),     32'd0);
    check({tag, ".words_loaded"}, 32'(words_loaded),   32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input bq_t q, input int max_gap,
                               input bit exp_done, input bit exp_err, input int exp_words);
    int nw;
    model(q);
    got.delete();
    send_frame(q, max_gap);
    #2;
    check({tag, ".load_done"},    32'(load_done),    32'(exp_done));
    check({tag, ".load_error"},   32'(load_error),   32'(exp_err));
    check({tag, ".cpu_reset"},    32'(cpu_reset),    32'(!exp_done));
    check({tag, ".in_ready"},     32'(bus.in_ready), 32'd0);
    check({tag, ".words_loaded"}, 32'(words_loaded), 32'(exp_words));
    check({tag, ".n_writes"},     32'(got.size()),   32'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      check($sformatf("%s.wr%0d.addr", tag, i), 32'(got[i].addr), 32'(expq[i].addr));
      check($sformatf("%s.wr%0d.data", tag, i), 32'(got[i].data), 32'(expq[i].data));
    end
    // Hold a stray byte while the loader is finished: nothing may be accepted or written.
    nw = got.size();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, ".hold_writes"}, 32'(got.size()),   32'(nw));
    check({tag, ".hold_ready"},  32'(bus.in_ready), 32'd0);
    check({tag, ".hold_done"},   32'(load_done),    32'(exp_done));
    check({tag, ".hold_words"},  32'(words_loaded), 32'(exp_words));
  endtask

  function automatic vec_t mk(input logic [95:0] b, input int len, input int gap,
                              input bit d, input bit e, input int w);
    vec_t v;
    v.bytes = b;
    v.len   = 4'(len);
    v.gap   = 3'(gap);
    v.done  = d;
    v.err   = e;
    v.words = 16'(w);
    return v;
  endfunction

  initial begin
    vec_t        vecs[8];
    bq_t         q;
    int          n;
    logic [15:0] w, sum;

    vecs[0] = mk(96'h0003_0001_EC10_0000_EC11_0000, 10, 0, 1'b1, 1'b0, 3);
    vecs[1] = mk(96'h0003_0001_EC10_0000_EC12_0000, 10, 0, 1'b0, 1'b1, 3);
    vecs[2] = mk(96'h0000_0000_0000_0000_0000_0000,  4, 0, 1'b1, 1'b0, 0);
    vecs[3] = mk(96'h0000_0001_0000_0000_0000_0000,  4, 0, 1'b0, 1'b1, 0);
    vecs[4] = mk(96'h4001_0000_0000_0000_0000_0000,  2, 0, 1'b0, 1'b1, 0);
    vecs[5] = mk(96'h0003_0001_EC10_0000_EC11_0000, 10, 5, 1'b1, 1'b0, 3);
    vecs[6] = mk(96'h0002_FFFF_0002_0001_0000_0000,  8, 2, 1'b1, 1'b0, 2);
    vecs[7] = mk(96'h0001_FFFF_FFFF_0000_0000_0000,  6, 3, 1'b1, 1'b0, 1);

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset.rom_we",    32'(bus.rom_we),    32'd0);
    check("reset.rom_addr",  32'(bus.rom_addr),  32'd0);
    check("reset.rom_wdata", 32'(bus.rom_wdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      q.delete();
      for (int i = 0; i < int'(vecs[k].len); i++) q.push_back(vecs[k].bytes[95 - 8 * i -: 8]);
      run_and_check($sformatf("vec%0d", k), q, int'(vecs[k].gap),
                    vecs[k].done, vecs[k].err, int'(vecs[k].words));
      pulse_start();
      check_idle($sformatf("vec%0d.start", k));
    end

    // Reset in the middle of a frame, then a fresh one-word frame.
    got.delete();
    q = '{8'h00, 8'h03, 8'h00, 8'h01, 8'hEC, 8'h10};
    send_frame(q, 0);
    #2;
    check("midreset.pre_writes", 32'(got.size()), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("midreset");
    check("midreset.rom_addr",  32'(bus.rom_addr),  32'd0);
    check("midreset.rom_wdata", 32'(bus.rom_wdata), 32'd0);
    q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h12, 8'h34};
    run_and_check("after_reset", q, 0, 1'b1, 1'b0, 1);
    pulse_start();
    check_idle("after_reset.start");
    q = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_and_check("empty2", q, 1, 1'b1, 1'b0, 0);
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check_idle("start_and_reset");
    check("start_and_reset.rom_wdata", 32'(bus.rom_wdata), 32'd0);

    // Random frames, some with a corrupted checksum.
    for (int r = 0; r < 20; r++) begin
      n = int'($urandom_range(0, 8));
      q.delete();
      q.push_back(8'(n >> 8));
      q.push_back(8'(n));
      sum = 16'd0;
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        sum = sum + w;
        q.push_back(w[15:8]);
        q.push_back(w[7:0]);
      end
      if ($urandom_range(0, 3) == 0) sum = sum ^ (16'd1 << $urandom_range(0, 15));
      q.push_back(sum[15:8]);
      q.push_back(sum[7:0]);
      model(q);
      run_and_check($sformatf("rand%0d", r), q, int'($urandom_range(0, 5)), m_done, m_err, m_words);
      pulse_start();
      check_idle($sformatf("rand%0d.start", r));
    end

    // Largest legal program fills the ROM exactly.
    q.delete();
    q.push_back(8'(DEPTH >> 8));
    q.push_back(8'(DEPTH));
    sum = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      w = 16'($urandom);
      sum = sum + w;
      q.push_back(w[15:8]);
      q.push_back(w[7:0]);
    end
    q.push_back(sum[15:8]);
    q.push_back(sum[7:0]);
    run_and_check("full", q, 0, 1'b1, 1'b0, DEPTH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
